// File: rtl/id_stage_pipe.sv
// id_stage_pipe
//   Decode stage with an integrated ID/EX pipeline register. It reads the
//   register file and forwards results from MEM (highest priority) and WB. It
//   detects a load-use hazard and then holds IF/ID and inserts one bubble. It
//   honours EX back-pressure and flush, and keeps a saturating count of
//   stalled cycles.
// Ports
//   clk, rst_n                         clock, async active-low reset
//   in_valid_i, instr_i, pc_plus_4_i,  instruction held in IF/ID
//   interrupt_i
//   imm_sel_i, reg_dst_sel_i,          control-unit selects
//   branch_type_i
//   wr_i, wr_dst_i, wr_data_i          WB write port
//   fwd_en_i, fwd_dst_i, fwd_data_i    MEM-stage forward
//   ex_valid_i, ex_load_i, ex_dst_i    instruction currently in EX
//   ex_ready_i, flush_i                EX accept / kill ID/EX
//   id_stall_o, branch_pc_o            combinational stall and branch target
//   ex_*_o                             ID/EX register contents
//   stall_cnt_o                        saturating stalled-cycle counter
module id_stage_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] pc_plus_4_i,
  input  logic              interrupt_i,
  input  logic [1:0]        imm_sel_i,
  input  logic [1:0]        reg_dst_sel_i,
  input  logic              branch_type_i,
  input  logic              wr_i,
  input  logic [REG_AW-1:0] wr_dst_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              fwd_en_i,
  input  logic [REG_AW-1:0] fwd_dst_i,
  input  logic [DATA_W-1:0] fwd_data_i,
  input  logic              ex_valid_i,
  input  logic              ex_load_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic              ex_ready_i,
  input  logic              flush_i,
  output logic              id_stall_o,
  output logic [DATA_W-1:0] branch_pc_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_rd1_o,
  output logic [DATA_W-1:0] ex_rd2_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc_plus_4_o,
  output logic [REG_AW-1:0] ex_reg_dst_o,
  output logic              ex_interrupt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned NUM_REGS = 2 ** REG_AW;
  localparam bit          ZR       = (ZERO_REG != 0);

  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic [REG_AW-1:0] rs1, rs2, rd3, dst;
  logic [DATA_W-1:0] rd1, rd2, imm;
  logic              hazard;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d, ex_rd2_q, ex_rd2_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d, ex_pc_q, ex_pc_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
  logic              ex_int_q, ex_int_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Top nibble of the instruction carries no field this stage decodes.
  logic unused_instr_hi;
  assign unused_instr_hi = ^instr_i[31:28];

  assign rs1 = instr_i[24 +: REG_AW];
  assign rs2 = instr_i[20 +: REG_AW];
  assign rd3 = instr_i[16 +: REG_AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wr_i && !(ZR && wr_dst_i == '0)) begin
      rf_q[wr_dst_i] <= wr_data_i;
    end
  end

  // Hard-wired zero first, then the younger MEM result, then WB, then RF.
  assign rd1 = (ZR && rs1 == '0)                ? '0         :
               (fwd_en_i && fwd_dst_i == rs1)   ? fwd_data_i :
               (wr_i && wr_dst_i == rs1)        ? wr_data_i  : rf_q[rs1];
  assign rd2 = (ZR && rs2 == '0)                ? '0         :
               (fwd_en_i && fwd_dst_i == rs2)   ? fwd_data_i :
               (wr_i && wr_dst_i == rs2)        ? wr_data_i  : rf_q[rs2];

  always_comb begin
    imm = '0;
    case (imm_sel_i)
      2'b00:   imm = {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};
      2'b01:   imm = {{(DATA_W-19){instr_i[18]}}, instr_i[18:0]};
      default: imm = {{(DATA_W-27){instr_i[26]}}, instr_i[26:0]};
    endcase
  end

  always_comb begin
    dst = rd3;
    case (reg_dst_sel_i)
      2'b00:   dst = rs1;
      2'b01:   dst = rs2;
      default: dst = rd3;
    endcase
  end

  assign branch_pc_o = imm + (branch_type_i ? pc_plus_4_i : '0);

  // A load writing the hard-wired zero register can never feed a consumer.
  assign hazard = in_valid_i && ex_valid_i && ex_load_i &&
                  (ex_dst_i == rs1 || ex_dst_i == rs2) &&
                  !(ZR && ex_dst_i == '0);

  assign id_stall_o = hazard || !ex_ready_i;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rd1_d   = ex_rd1_q;
    ex_rd2_d   = ex_rd2_q;
    ex_imm_d   = ex_imm_q;
    ex_pc_d    = ex_pc_q;
    ex_dst_d   = ex_dst_q;
    ex_int_d   = ex_int_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (ex_ready_i) begin
      if (hazard) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d = in_valid_i;
        ex_rd1_d   = rd1;
        ex_rd2_d   = rd2;
        ex_imm_d   = imm;
        ex_pc_d    = pc_plus_4_i;
        ex_dst_d   = dst;
        ex_int_d   = interrupt_i;
      end
    end
  end

  assign stall_cnt_d = (id_stall_o && stall_cnt_q != {CNT_W{1'b1}}) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rd1_q    <= '0;
      ex_rd2_q    <= '0;
      ex_imm_q    <= '0;
      ex_pc_q     <= '0;
      ex_dst_q    <= '0;
      ex_int_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd1_q    <= ex_rd1_d;
      ex_rd2_q    <= ex_rd2_d;
      ex_imm_q    <= ex_imm_d;
      ex_pc_q     <= ex_pc_d;
      ex_dst_q    <= ex_dst_d;
      ex_int_q    <= ex_int_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_rd1_o       = ex_rd1_q;
  assign ex_rd2_o       = ex_rd2_q;
  assign ex_imm_o       = ex_imm_q;
  assign ex_pc_plus_4_o = ex_pc_q;
  assign ex_reg_dst_o   = ex_dst_q;
  assign ex_interrupt_o = ex_int_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule
